// File: rtl/tile_board.sv
// tile_board: 6x6 tile colour/hidden/selected store with wrapping cursor
// and two-tile selection FSM that applies matcher verdicts.
module tile_board #(
  parameter logic [107:0] TILE_INIT = 108'h0,
  parameter int           PAIRS     = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mv_up,
  input  logic        mv_down,
  input  logic        mv_left,
  input  logic        mv_right,
  input  logic        sel_btn,
  input  logic        ms,
  input  logic        mf,
  input  logic [5:0]  addr,
  output logic        r,
  output logic        g,
  output logic        b,
  output logic [35:0] sel_bus,
  output logic [35:0] hidden_bus,
  output logic [5:0]  cursor,
  output logic [4:0]  pairs_left,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, ONE, TWO} state_t;

  state_t      state, state_n;
  logic [2:0]  row, col, row_n, col_n;
  logic [5:0]  a_q, b_q, a_n, b_n;
  logic [35:0] sel_q, sel_n, hid_q, hid_n;
  logic [4:0]  pl_q, pl_n;
  logic        ms_q, mf_q;
  logic        ms_rise, mf_rise, sel_ok, succ;
  logic [5:0]  cur;

  function automatic logic [2:0] colour(input logic [5:0] k);
    if (k > 6'd35) return 3'b000;
    return TILE_INIT[int'(k)*3 +: 3];
  endfunction

  assign {r, g, b} = colour(addr);

  assign cur = {1'b0, row, 2'b00} + {2'b00, row, 1'b0} + {3'b000, col};

  assign ms_rise = ms & ~ms_q;
  assign mf_rise = mf & ~mf_q;
  assign done    = (pl_q == 5'd0);
  assign sel_ok  = sel_btn & ~done & ~hid_q[cur];
  // simultaneous ms/mf counts as failure even if only ms just rose
  assign succ    = ms_rise & ~mf & (colour(a_q) == colour(b_q));

  always_comb begin
    row_n   = row;
    col_n   = col;
    state_n = state;
    a_n     = a_q;
    b_n     = b_q;
    sel_n   = sel_q;
    hid_n   = hid_q;
    pl_n    = pl_q;

    if (mv_up)
      row_n = (row == 3'd0) ? 3'd5 : row - 3'd1;
    else if (mv_down)
      row_n = (row == 3'd5) ? 3'd0 : row + 3'd1;
    else if (mv_left)
      col_n = (col == 3'd0) ? 3'd5 : col - 3'd1;
    else if (mv_right)
      col_n = (col == 3'd5) ? 3'd0 : col + 3'd1;

    unique case (state)
      IDLE: begin
        if (sel_ok) begin
          sel_n[cur] = 1'b1;
          a_n        = cur;
          state_n    = ONE;
        end
      end
      ONE: begin
        if (sel_ok) begin
          if (cur == a_q) begin
            sel_n[a_q] = 1'b0;
            state_n    = IDLE;
          end else begin
            sel_n[cur] = 1'b1;
            b_n        = cur;
            state_n    = TWO;
          end
        end
      end
      TWO: begin
        if (ms_rise || mf_rise) begin
          sel_n[a_q] = 1'b0;
          sel_n[b_q] = 1'b0;
          state_n    = IDLE;
          if (succ) begin
            hid_n[a_q] = 1'b1;
            hid_n[b_q] = 1'b1;
            if (pl_q != 5'd0) pl_n = pl_q - 5'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      row   <= 3'd0;
      col   <= 3'd0;
      a_q   <= 6'd0;
      b_q   <= 6'd0;
      sel_q <= 36'd0;
      hid_q <= 36'd0;
      pl_q  <= 5'(PAIRS);
      ms_q  <= 1'b0;
      mf_q  <= 1'b0;
    end else begin
      state <= state_n;
      row   <= row_n;
      col   <= col_n;
      a_q   <= a_n;
      b_q   <= b_n;
      sel_q <= sel_n;
      hid_q <= hid_n;
      pl_q  <= pl_n;
      ms_q  <= ms;
      mf_q  <= mf;
    end
  end

  // selected flags leave MSB-first: tile k on bit 35-k
  always_comb begin
    sel_bus = '0;
    for (int i = 0; i < 36; i++) sel_bus[35-i] = sel_q[i];
  end

  assign hidden_bus = hid_q;
  assign cursor     = cur;
  assign pairs_left = pl_q;
  assign busy       = (state == TWO);

endmodule

// File: doc/tile_board.md
# tile_board

Game-board state store for the 6x6 tile grid. Holds each tile's 3-bit colour, hidden (removed) flag and selected flag, and moves a wrapping player cursor. It serves the matcher's colour reads on `addr`/`r`/`g`/`b`, drives `sel_bus`/`hidden_bus` to the matcher, and applies the matcher's `ms`/`mf` verdicts by removing or deselecting the selected pair.

## Interface
- `TILE_INIT`, default 108'h0: initial colours, 3 bits per tile; tile k at bits [3k+2:3k], bit order {r,g,b}.
- `PAIRS`, default 18: pair count loaded into `pairs_left` at reset.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `mv_up`, `mv_down`, `mv_left`, `mv_right`  in  1 each  single-cycle move pulses from the upstream debouncer.
- `sel_btn`  in  1  single-cycle select pulse.
- `ms`  in  1  match-success pulse from the matcher.
- `mf`  in  1  match-failure pulse from the matcher.
- `addr`  in  6  tile index read by the matcher, 0..35.
- `r`, `g`, `b`  out  1 each  colour of tile `addr`.
- `sel_bus`  out  36  selected flags; tile k is bit [35-k].
- `hidden_bus`  out  36  removed flags; tile k is bit [k]; 1 means removed.
- `cursor`  out  6  cursor tile index, row*6+col.
- `pairs_left`  out  5  remaining pairs.
- `busy`  out  1  high in state TWO.
- `done`  out  1  high when `pairs_left`==0.

## Operation
- Tile k sits at row k/6, col k%6. Colour store is loaded from `TILE_INIT` at reset and never written afterwards.
- Read port is combinational: {r,g,b} = colour[addr]. Removed tiles still return their colour. `addr` > 35 returns 3'b000.
- Cursor:
  - `mv_up`: row-1, wrapping 0 to 5. `mv_down`: row+1, wrapping 5 to 0.
  - `mv_left`: col-1, wrapping 0 to 5, same row. `mv_right`: col+1, wrapping 5 to 0.
  - If several move pulses arrive in one cycle, priority is up > down > left > right; only one move is applied.
  - Moves are accepted in every state.
- Selection FSM, states IDLE (0 selected), ONE (1 selected), TWO (2 selected, awaiting verdict):
  - IDLE, `sel_btn` on a non-removed tile: set its bit, record it as A, go to ONE. On a removed tile: ignored.
  - ONE, `sel_btn` on A: clear A, go to IDLE.
  - ONE, `sel_btn` on another non-removed tile: set its bit, record it as B, go to TWO. On a removed tile: ignored.
  - TWO: `sel_btn` ignored.
  - TWO, rising edge of `ms` with colour[A]==colour[B]: hidden[A] and hidden[B] set, both selected bits cleared, `pairs_left` decremented, go to IDLE.
  - TWO, rising edge of `ms` with unequal colours, or rising edge of `mf`: both selected bits cleared, hidden unchanged, go to IDLE.
  - `ms` and `mf` high together: treated as failure.
  - `ms`/`mf` outside TWO: ignored. The rising-edge detector still tracks them.
- `pairs_left` saturates at 0. `done` = (`pairs_left`==0). While `done`, `sel_btn` is ignored.
- Simultaneous `sel_btn` and a move: select applies to the pre-move cursor; the move applies in the same edge.

## Timing
- Reset values: `sel_bus`=0, `hidden_bus`=0, `cursor`=0, `pairs_left`=`PAIRS`, FSM=IDLE, `busy`=0, `done`=(`PAIRS`==0). Edge-detect history = 0. {r,g,b} follows `addr` during reset.
- `rst` mid-operation, including in TWO: everything returns to reset values immediately; the colour store is reloaded.
- `sel_bus`, `hidden_bus`, `cursor`, `pairs_left`, `busy` are registered. Each updates one edge after the input pulse is sampled.
- Verdict latency: `ms`/`mf` sampled high at edge N (previous sample 0) -> buses updated after edge N. Pulses of one or more cycles count as a single event.
- Read port has zero-cycle latency: colour is valid in the same cycle `addr` changes, so the matcher can sample it at the next edge.

## Test plan
- Cursor wrap: from reset, `mv_up` -> cursor 30; `mv_left` -> 35; `mv_right` -> 30; `mv_down` -> 0.
- Select/deselect: select tile 0 -> `sel_bus`=36'h8_0000_0000, `busy`=0. Select tile 0 again -> `sel_bus`=0. Select tiles 0 then 1 -> `sel_bus`=36'hC_0000_0000, `busy`=1. Third `sel_btn` -> no change.
- Successful match: tiles 0 and 7 both colour 3'b101, both selected, 1-cycle `ms` -> `hidden_bus`=36'h0_0000_0081, `sel_bus`=0, `pairs_left`=17, `busy`=0.
- Colour veto and failure: tiles with colours 3'b001 and 3'b010 selected, `ms` -> `hidden_bus` unchanged, `sel_bus`=0. Repeat with `mf` -> same result. With `ms`=`mf`=1 together -> same result.
- Removed tile and multi-cycle verdict: `sel_btn` on a hidden tile -> ignored. `ms` held 3 cycles -> `pairs_left` decremented exactly once.
- Read port and end of game: sweep `addr` 0..35 and check {r,g,b} against `TILE_INIT`; `addr`=40 -> 0. Clear all 18 pairs -> `done`=1, `pairs_left`=0, `sel_btn` ignored. Assert `rst` in TWO -> all outputs return to reset values.
